// File: rtl/pipe_fetch_ctrl_if.sv
// rtl/pipe_fetch_ctrl_if.sv - instruction memory fetch bus between fetch controller and memory
interface pipe_fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdy,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdy,
      output imem_data
   );
endinterface

// File: rtl/pipe_fetch_ctrl.sv
// rtl/pipe_fetch_ctrl.sv - pipeline fetch controller with memory timeout; FETCH_PERF_EN adds fetch/stall counters
module pipe_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         pcsource,
   input  logic [31:0]        bpc,
   input  logic [31:0]        rpc,
   input  logic [31:0]        jpc,
   input  logic               stall,
   pipe_fetch_ctrl_if.master  imem,
   output logic [31:0]        pc,
   output logic [31:0]        pc4,
   output logic [31:0]        inst,
   output logic               inst_valid,
   output logic               fetch_err
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_t;

   // counter value at which one more empty REQ cycle means timeout
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  wait_cnt;
   logic [31:0] pc_nxt;
   logic        accept;
   logic        timeout_hit;

   // acceptance happens only in VALID without stall; targets are ignored otherwise
   assign accept      = (state == VALID) && !stall;
   // an imem_rdy in the final cycle takes priority over the timeout
   assign timeout_hit = (state == REQ) && !imem.imem_rdy && (wait_cnt == WAIT_LAST);
   assign pc4         = pc + 32'd4;
   assign imem.imem_addr = pc;

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic; IDLE is terminal once a timeout has occurred
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fetch_err) state_nxt = REQ;
         REQ: begin
            if (imem.imem_rdy)    state_nxt = VALID;
            else if (timeout_hit) state_nxt = IDLE;
         end
         VALID:   if (accept) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      imem.imem_req = (state == REQ);
      inst_valid    = (state == VALID);
   end

   // next-PC select, used only on the acceptance cycle
   always_comb begin
      pc_nxt = pc4;
      case (pcsource)
         2'b00:   pc_nxt = pc4;
         2'b01:   pc_nxt = bpc;
         2'b10:   pc_nxt = rpc;
         default: pc_nxt = jpc;
      endcase
   end

   // pc, instruction buffer, wait counter and sticky error
   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= RESET_PC;
         inst      <= 32'd0;
         wait_cnt  <= 8'd0;
         fetch_err <= 1'b0;
      end else begin
         if (accept) begin
            pc <= pc_nxt;
         end
         if ((state == REQ) && imem.imem_rdy) begin
            inst <= imem.imem_data;
         end
         // held at zero outside REQ so every REQ entry starts from zero
         if (state != REQ) begin
            wait_cnt <= 8'd0;
         end else if (!imem.imem_rdy) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (timeout_hit) begin
            fetch_err <= 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_EN
   // performance counters, free-running modulo 2^32
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (accept) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if ((state == VALID) && stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/pipe_fetch_ctrl.md
PIPE_FETCH_CTRL -- requirements
Module: pipe_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, SHALL be the maximum number of REQ cycles without imem_rdy before a fetch error (range 1..255).
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 pcsource  input  2  next-PC select: 00 pc4, 01 bpc, 10 rpc, 11 jpc.
REQ-006 bpc, rpc, jpc  input  32 each  branch, register and jump targets from ID.
REQ-007 stall  input  1  high SHALL block acceptance of the delivered instruction.
REQ-008 imem_rdy  input  1  memory has returned imem_data for the current imem_addr.
REQ-009 imem_data  input  32  instruction word, valid only when imem_rdy=1.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 imem_addr  output  32  fetch address, equal to pc.
REQ-012 pc  output  32  current fetch PC.
REQ-013 pc4  output  32  pc+4, modulo 2^32.
REQ-014 inst  output  32  buffered instruction.
REQ-015 inst_valid  output  1  inst holds an instruction awaiting acceptance.
REQ-016 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ, VALID.
REQ-018 IDLE: imem_req=0, inst_valid=0; SHALL go to REQ on the next cycle unless fetch_err=1.
REQ-019 REQ: imem_req=1, imem_addr=pc held stable; on imem_rdy=1 SHALL latch imem_data into inst and go to VALID.
REQ-020 VALID: inst_valid=1, imem_req=0, inst stable; when stall=0, acceptance SHALL occur that cycle.
REQ-021 On acceptance, pc SHALL load pc4/bpc/rpc/jpc per pcsource sampled that cycle, and the FSM SHALL go to REQ.
REQ-022 pcsource and targets SHALL be ignored on all non-acceptance cycles.
REQ-023 While stall=1 in VALID, pc, inst and the state SHALL hold indefinitely.
REQ-024 imem_rdy outside REQ SHALL be ignored.
REQ-025 Latency: first imem_req two cycles after reset deasserts; with zero-wait memory and no stall, one instruction SHALL be accepted every 2 cycles.
REQ-026 A wait counter SHALL clear on REQ entry and increment each REQ cycle with imem_rdy=0.
REQ-027 When it reaches TIMEOUT, fetch_err SHALL set, the FSM SHALL go to IDLE and stay there until reset.
REQ-028 imem_rdy arriving in the same cycle the counter reaches TIMEOUT SHALL win: data latched, no error.
REQ-029 pc4 SHALL wrap: pc=32'hFFFF_FFFC gives pc4=32'h0000_0000.
REQ-030 Target values SHALL load unmodified; the block SHALL NOT check alignment.

Reset
REQ-031 Under reset=1: pc=RESET_PC, state=IDLE, inst=0, inst_valid=0, imem_req=0, fetch_err=0, wait counter=0, perf counters=0.
REQ-032 Reset asserted in any state, including mid-REQ, SHALL take effect at the next edge and discard any in-flight fetch.

Configuration
REQ-033 Macro FETCH_PERF_EN defined: add outputs fetch_cnt[31:0] (+1 per acceptance) and stall_cnt[31:0] (+1 per VALID cycle with stall=1). Both SHALL wrap modulo 2^32.
REQ-034 Macro FETCH_PERF_EN undefined: these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Reset release, imem_rdy tied 1, stall=0, pcsource=00: imem_addr sequence 0x0, 0x4, 0x8, with imem_req high every second cycle.
REQ-036 In VALID with pc=0x40 and stall=1 for 5 cycles, then stall=0 with pcsource=01, bpc=0x100: inst held for 5 cycles, next imem_addr=0x100, stall_cnt=5 (FETCH_PERF_EN).
REQ-037 imem_rdy withheld 15 cycles: fetch_err=1, imem_req=0, FSM stays in IDLE; rdy on cycle 15: inst latched, fetch_err=0.
REQ-038 pc=0xFFFF_FFFC, pcsource=00 accepted: next pc=0x0000_0000.
REQ-039 Reset asserted mid-REQ, then imem_rdy=1 the cycle after: inst_valid stays 0, pc=RESET_PC.
REQ-040 pcsource=11 toggled while in REQ and deasserted before acceptance: pc advances by 4 only.
